keypad_scanner: RTL and testbench

- Scans a 4x4 matrix keypad, debounces presses and encodes them to the 4-bit key code consumed by the calculator input FSM (tecla/ready).
- Emits exactly one single-cycle ready pulse per debounced press, so the downstream FSM advances once per keystroke.
- Sits between the board keypad pins and the calculator input FSM.

---
 rtl/calc_pkg.sv | 51 +++++
 rtl/kp_sync.sv | 23 ++
 rtl/keypad_scanner.sv | 155 +++++++++++++++
 tb/tb_keypad_scanner.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - key codes, scanner state type and keypad map shared by the calculator front end
package calc_pkg;

    localparam logic [3:0] KEY_0    = 4'd0;
    localparam logic [3:0] KEY_1    = 4'd1;
    localparam logic [3:0] KEY_2    = 4'd2;
    localparam logic [3:0] KEY_3    = 4'd3;
    localparam logic [3:0] KEY_4    = 4'd4;
    localparam logic [3:0] KEY_5    = 4'd5;
    localparam logic [3:0] KEY_6    = 4'd6;
    localparam logic [3:0] KEY_7    = 4'd7;
    localparam logic [3:0] KEY_8    = 4'd8;
    localparam logic [3:0] KEY_9    = 4'd9;
    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } scan_state_t;

    // Physical keypad layout: row r, column c (both counted from 0).
    function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = KEY_1;
            4'h1: code = KEY_2;
            4'h2: code = KEY_3;
            4'h3: code = KEY_A;
            4'h4: code = KEY_4;
            4'h5: code = KEY_5;
            4'h6: code = KEY_6;
            4'h7: code = KEY_B;
            4'h8: code = KEY_7;
            4'h9: code = KEY_8;
            4'hA: code = KEY_9;
            4'hB: code = KEY_C;
            4'hC: code = KEY_STAR;
            4'hD: code = KEY_0;
            4'hE: code = KEY_HASH;
            default: code = KEY_D;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/kp_sync.sv
// rtl/kp_sync.sv - 4-bit two-flop synchronizer for the keypad row pins
// Ports: clk, reset (sync active-low, idles to 4'b1111), d (async rows), q (synchronized rows)
module kp_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    // Reset value is "no key" so nothing is seen as pressed right after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= 4'b1111;
            q    <= 4'b1111;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad scanner with debounce, key encoding and one-shot ready
// Ports: clk, reset (sync active-low), row (async active-low rows), col (active-low one-hot drive),
//        tecla (last accepted key code), ready (one-cycle strobe with new tecla), key_down (press held)
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] tecla,
    output logic       ready,
    output logic       key_down
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CNT);

    logic [3:0]       rs;
    scan_state_t      state, state_nxt;
    logic [DIV_W-1:0] div;
    logic [1:0]       cand_r, cand_r_nxt, cand_c, cand_c_nxt;
    logic [1:0]       hit_r, col_idx;
    logic             hit, sample;
    logic [CNT_W-1:0] dcnt, dcnt_nxt, dcnt_inc;
    logic [CNT_W-1:0] rcnt, rcnt_nxt, rcnt_inc;
    logic [3:0]       col_nxt, col_rot, tecla_nxt;
    logic             ready_nxt, key_down_nxt;

    kp_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (row),
        .q     (rs)
    );

    // Exactly one row low is a hit; ghosting / multi-key patterns are ignored.
    always_comb begin
        hit   = 1'b0;
        hit_r = 2'd0;
        case (rs)
            4'b1110: begin hit = 1'b1; hit_r = 2'd0; end
            4'b1101: begin hit = 1'b1; hit_r = 2'd1; end
            4'b1011: begin hit = 1'b1; hit_r = 2'd2; end
            4'b0111: begin hit = 1'b1; hit_r = 2'd3; end
            default: ;
        endcase
    end

    always_comb begin
        col_idx = 2'd0;
        case (col)
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase
    end

    assign sample   = (div == DIV_LAST);
    assign col_rot  = {col[2:0], col[3]};
    assign dcnt_inc = (dcnt == CNT_DONE) ? dcnt : dcnt + CNT_W'(1);
    assign rcnt_inc = (rcnt == CNT_DONE) ? rcnt : rcnt + CNT_W'(1);

    always_comb begin
        state_nxt    = state;
        col_nxt      = col;
        tecla_nxt    = tecla;
        ready_nxt    = 1'b0;
        key_down_nxt = key_down;
        cand_r_nxt   = cand_r;
        cand_c_nxt   = cand_c;
        dcnt_nxt     = dcnt;
        rcnt_nxt     = rcnt;
        case (state)
            SCAN: begin
                if (sample) begin
                    if (hit) begin
                        cand_r_nxt = hit_r;
                        cand_c_nxt = col_idx;
                        dcnt_nxt   = '0;
                        state_nxt  = DEBOUNCE;
                    end else begin
                        col_nxt = col_rot;
                    end
                end
            end
            DEBOUNCE: begin
                if (sample) begin
                    if (hit && hit_r == cand_r) begin
                        dcnt_nxt = dcnt_inc;
                        // Accept on the final matching sample so ready lands one cycle later.
                        if (dcnt_inc == CNT_DONE) begin
                            state_nxt    = HELD;
                            tecla_nxt    = keymap(cand_r, cand_c);
                            ready_nxt    = 1'b1;
                            key_down_nxt = 1'b1;
                            rcnt_nxt     = '0;
                        end
                    end else begin
                        state_nxt = SCAN;
                        col_nxt   = col_rot;
                    end
                end
            end
            HELD: begin
                if (sample) begin
                    if (rs == 4'b1111) begin
                        rcnt_nxt = rcnt_inc;
                        if (rcnt_inc == CNT_DONE) begin
                            key_down_nxt = 1'b0;
                            state_nxt    = SCAN;
                            col_nxt      = col_rot;
                        end
                    end else begin
                        rcnt_nxt = '0;
                    end
                end
            end
            default: state_nxt = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= SCAN;
            div      <= '0;
            col      <= 4'b1110;
            tecla    <= 4'd0;
            ready    <= 1'b0;
            key_down <= 1'b0;
            cand_r   <= 2'd0;
            cand_c   <= 2'd0;
            dcnt     <= '0;
            rcnt     <= '0;
        end else begin
            state    <= state_nxt;
            div      <= sample ? '0 : div + DIV_W'(1);
            col      <= col_nxt;
            tecla    <= tecla_nxt;
            ready    <= ready_nxt;
            key_down <= key_down_nxt;
            cand_r   <= cand_r_nxt;
            cand_c   <= cand_c_nxt;
            dcnt     <= dcnt_nxt;
            rcnt     <= rcnt_nxt;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner with a keypad matrix model
module tb_keypad_scanner;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  tecla;
    logic        ready;
    logic        key_down;
    logic [15:0] pressed = 16'h0;

    int checks = 0;
    int errors = 0;

    // Key code printed on each physical key, indexed r*4+c.
    int kmap[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT)) dut (
        .clk      (clk),
        .reset    (reset),
        .row      (row),
        .col      (col),
        .tecla    (tecla),
        .ready    (ready),
        .key_down (key_down)
    );

    always #5 clk = ~clk;

    // Matrix model: a closed switch pulls its row low while its column is driven low.
    function automatic logic [3:0] keypad_rows(input logic [15:0] p, input logic [3:0] cdrv);
        logic [3:0] rr;
        rr = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (p[r*4+c] && !cdrv[c]) rr[r] = 1'b0;
        return rr;
    endfunction

    assign row = keypad_rows(pressed, col);

    function automatic int pos_of(input int code);
        for (int i = 0; i < 16; i++)
            if (kmap[i] == code) return i;
        return 0;
    endfunction

    // Ready monitor: records every accepted code and checks strobe rules.
    int         ready_cnt = 0;
    logic [3:0] got[$];
    logic       prev_ready = 1'b0;
    logic [3:0] prev_tecla = 4'd0;
    logic       prev_reset = 1'b0;

    always @(negedge clk) begin
        if (ready) begin
            ready_cnt++;
            got.push_back(tecla);
        end
        if (reset && prev_reset) begin
            checks++;
            if (ready && prev_ready) begin
                errors++;
                $display("FAIL ready_consecutive: ready high two cycles, required single pulse");
            end
            checks++;
            if (tecla !== prev_tecla && !ready) begin
                errors++;
                $display("FAIL tecla_stable: tecla changed %0d -> %0d without ready", prev_tecla, tecla);
            end
        end
        prev_ready = ready;
        prev_tecla = tecla;
        prev_reset = reset;
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        align();
        reset = 1'b0;
        align();
        reset = 1'b1;
    endtask

    // Waits for the first cycle of the given column window; returns at posedge+1 after it.
    task automatic wait_col_start(input logic [3:0] want);
        int n;
        n = 0;
        @(negedge clk);
        while (col === want && n < 64) begin @(negedge clk); n++; end
        while (col !== want && n < 64) begin @(negedge clk); n++; end
        checks++;
        if (n >= 64) begin
            errors++;
            $display("FAIL wait_col: col=%b never reached %b", col, want);
        end
        align();
    endtask

    task automatic press_key(input int p, input int hold, input int rel);
        pressed[p] = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        pressed[p] = 1'b0;
        repeat (rel) @(posedge clk);
        #1;
    endtask

    task automatic check_scanning(input string name);
        logic [3:0] seen;
        seen = 4'h0;
        for (int i = 0; i < 4 * SCAN_DIV; i++) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) if (col == (4'hF ^ (4'b0001 << c))) seen[c] = 1'b1;
        end
        checks++;
        if (seen !== 4'hF) begin
            errors++;
            $display("FAIL %s_scanning: columns visited %b, required 1111", name, seen);
        end
        align();
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        pressed = 16'h0;
        do_reset();
        for (int i = 0; i < 4 * SCAN_DIV; i++) begin
            @(negedge clk);
            exp_col = 4'hF ^ (4'b0001 << ((i / SCAN_DIV) % 4));
            checks++;
            if (col !== exp_col || ready !== 1'b0 || tecla !== 4'd0 || key_down !== 1'b0) begin
                errors++;
                $display("FAIL reset_state cycle %0d: col=%b ready=%b tecla=%0d key_down=%b, required col=%b 0 0 0",
                         i, col, ready, tecla, key_down, exp_col);
            end
        end
    endtask

    task automatic test_press5();
        int base, first_ready, first_up, exp_up, s0, exp_lat;
        logic [3:0] col_up;
        pressed = 16'h0;
        do_reset();
        pressed[1*4+1] = 1'b1;
        base = ready_cnt;
        first_ready = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ready && first_ready < 0) first_ready = i;
        end
        // Column 1 is driven from cycle SCAN_DIV; its last dwell cycle is the detecting sample.
        exp_lat = (2 * SCAN_DIV - 1) + DEBOUNCE_CNT * SCAN_DIV + 1;
        checks++;
        if (first_ready != exp_lat) begin
            errors++;
            $display("FAIL press5_latency: ready at cycle %0d, required %0d", first_ready, exp_lat);
        end
        checks++;
        if (ready_cnt - base != 1 || tecla !== 4'(kmap[5])) begin
            errors++;
            $display("FAIL press5_code: pulses=%0d tecla=%0d, required 1 pulse tecla=%0d", ready_cnt - base, tecla, kmap[5]);
        end
        checks++;
        if (key_down !== 1'b1) begin
            errors++;
            $display("FAIL press5_key_down: key_down=%b while held, required 1", key_down);
        end
        align();
        pressed = 16'h0;
        s0 = 102;
        while (s0 % SCAN_DIV != SCAN_DIV - 1) s0++;
        exp_up = s0 + (DEBOUNCE_CNT - 1) * SCAN_DIV + 1;
        first_up = -1;
        col_up = 4'h0;
        for (int i = 100; i < 140; i++) begin
            @(negedge clk);
            if (!key_down && first_up < 0) begin first_up = i; col_up = col; end
        end
        checks++;
        if (first_up != exp_up || col_up !== 4'b1011) begin
            errors++;
            $display("FAIL press5_release: key_down fell at %0d col=%b, required %0d col=1011", first_up, col_up, exp_up);
        end
        check_scanning("press5");
    endtask

    task automatic run_sequence(input string name, input int codes[$], input int hmin, input int hmax);
        int base;
        base = ready_cnt;
        got.delete();
        foreach (codes[k])
            press_key(pos_of(codes[k]), $urandom_range(hmax, hmin), $urandom_range(hmax, hmin));
        checks++;
        if (ready_cnt - base != codes.size()) begin
            errors++;
            $display("FAIL %s_count: %0d ready pulses, required %0d", name, ready_cnt - base, codes.size());
        end
        foreach (codes[k]) begin
            checks++;
            if (k >= got.size() || got[k] !== 4'(codes[k])) begin
                errors++;
                $display("FAIL %s_code[%0d]: got %0d, required %0d", name, k, (k < got.size()) ? int'(got[k]) : -1, codes[k]);
            end
        end
    endtask

    task automatic test_sequence();
        int codes[$];
        codes = '{7, 10, 3, 13};
        align();
        run_sequence("sequence", codes, 40, 40);
    endtask

    task automatic test_reset_mid();
        int base;
        align();
        wait_col_start(4'b1011);
        pressed[2*4+2] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        base = ready_cnt;
        reset = 1'b0;
        pressed = 16'h0;
        @(negedge clk);
        align();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (col !== 4'b1110 || tecla !== 4'd0 || ready !== 1'b0 || key_down !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_state: col=%b tecla=%0d ready=%b key_down=%b, required 1110 0 0 0",
                     col, tecla, ready, key_down);
        end
        repeat (40) @(negedge clk);
        checks++;
        if (ready_cnt != base) begin
            errors++;
            $display("FAIL reset_mid_abort: %0d ready pulses, required 0", ready_cnt - base);
        end
        align();
        base = ready_cnt;
        press_key(2*4+2, 40, 40);
        checks++;
        if (ready_cnt - base != 1 || tecla !== 4'(kmap[2*4+2])) begin
            errors++;
            $display("FAIL reset_mid_repress: pulses=%0d tecla=%0d, required 1 pulse tecla=9", ready_cnt - base, tecla);
        end
    endtask

    task automatic test_bounce();
        int base;
        align();
        wait_col_start(4'b1101);
        base = ready_cnt;
        press_key(3*4+1, 6, 60);
        checks++;
        if (ready_cnt != base || key_down !== 1'b0) begin
            errors++;
            $display("FAIL bounce: pulses=%0d key_down=%b, required 0 0", ready_cnt - base, key_down);
        end
        check_scanning("bounce");
    endtask

    task automatic test_two_keys();
        int base;
        align();
        base = ready_cnt;
        pressed[0*4+0] = 1'b1;
        pressed[2*4+0] = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        checks++;
        if (ready_cnt != base || key_down !== 1'b0) begin
            errors++;
            $display("FAIL two_keys: pulses=%0d key_down=%b, required 0 0", ready_cnt - base, key_down);
        end
        check_scanning("two_keys");
        pressed = 16'h0;
        repeat (40) @(posedge clk);
        #1;
    endtask

    task automatic test_long_hold();
        int codes[$];
        codes = '{kmap[$urandom_range(15, 0)]};
        run_sequence("long_hold", codes, 1000, 1000);
    endtask

    task automatic test_random();
        int codes[$];
        for (int k = 0; k < 10; k++) codes.push_back(kmap[$urandom_range(15, 0)]);
        run_sequence("random", codes, 40, 80);
    endtask

    initial begin
        test_reset();
        test_press5();
        test_sequence();
        test_reset_mid();
        test_bounce();
        test_two_keys();
        test_long_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
